crem_cmd_ctrl: RTL and testbench
================================

# crem_cmd_ctrl

Parametrised command/response controller for the CREM system: consumes a byte stream from the UART receive path (post-synchroniser), decodes register-write, register-read, and ALU frames, and drives the register file, ALU, clock gate, and transmit FIFO. Successor to the fixed 8-bit controller:
- generic data/address width
- 2-word ALU results sent LSB first
- a frame timeout that aborts stalled frames and waits
- optional error responses

## Interface
Parameters:
- DATA_WIDTH, 8, width of RX/TX words, register data, ALU operands
- ADDR_WIDTH, 4, register-file address width
- FUN_WIDTH, 4, ALU function code width
- TIMEOUT_CYCLES, 1024, idle cycles tolerated mid-frame or in a wait state (≥2)

Ports:
- CLK  in  1  single clock domain (REF_CLK domain)
- RST  in  1  reset, synchronous, active-low
- RX_DATA  in  DATA_WIDTH  received word
- RX_VALID  in  1  one-cycle strobe, RX_DATA valid
- REG_WR_EN  out  1  one-cycle register write strobe
- REG_RD_EN  out  1  one-cycle register read strobe
- REG_ADDR  out  ADDR_WIDTH  register address
- REG_WR_DATA  out  DATA_WIDTH  register write data
- REG_RD_DATA  in  DATA_WIDTH  register read data
- REG_RD_VALID  in  1  read data valid strobe
- ALU_EN  out  1  ALU enable, level
- ALU_FUN  out  FUN_WIDTH  ALU function
- GATE_EN  out  1  ALU clock-gate enable, level
- ALU_OUT  in  2*DATA_WIDTH  ALU result
- ALU_OUT_VALID  in  1  result valid strobe
- TX_DATA  out  DATA_WIDTH  word to TX FIFO
- TX_VALID  out  1  one-cycle FIFO write strobe
- TX_FULL  in  1  TX FIFO full
- OVR_ERR  out  1  one-cycle pulse, RX word dropped

## Operation
- Opcodes compare full RX_DATA, zero-extended:
  - 0xAA: write frame `AA, addr, data`
  - 0xBB: read frame `BB, addr`
  - 0xCC: ALU with operands `CC, A, B, fun`
  - 0xDD: ALU without operands `DD, fun`
- Address and function codes take the low ADDR_WIDTH / FUN_WIDTH bits of the received word.
- FSM states: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OP_A, OP_B, FUN, ALU_WAIT, TX_RD, TX_LO, TX_HI, ERR.
- **IDLE:** AA→WR_ADDR, BB→RD_ADDR, CC→OP_A, DD→FUN. Any other word goes to ERR (macro on) or is ignored (macro off).
- **Write frame:** WR_ADDR latches the address. On the data word in WR_DATA, REG_WR_EN pulses in the next cycle with REG_ADDR/REG_WR_DATA; then IDLE.
- **Read frame:** on the address word in RD_ADDR, REG_RD_EN pulses in the next cycle; then RD_WAIT. On REG_RD_VALID, data is captured; then TX_RD.
- **ALU with operands:**
  - Operand A is written to register 0 (REG_WR_EN pulse, as in write frame); then OP_B.
  - Operand B is written to register 1; then FUN.
- **FUN:** on the function word, ALU_FUN latches and ALU_EN and GATE_EN go high the next cycle; then ALU_WAIT. On ALU_OUT_VALID, the result is captured, ALU_EN and GATE_EN drop the following cycle; then TX_LO.
- **TX states:** the word is pushed with TX_VALID only in a cycle where TX_FULL=0; otherwise hold.
  - TX_LO pushes ALU_OUT[DATA_WIDTH-1:0], then TX_HI pushes the upper word, then IDLE.
  - TX_RD pushes the read data, then IDLE.
- **RX words arriving outside receive states** (IDLE, WR_*, RD_ADDR, OP_*, FUN) are dropped and OVR_ERR pulses.
- **Timeout:** the counter clears on every accepted word and on entry to any state. In any non-IDLE state other than TX_* and ERR, reaching TIMEOUT_CYCLES cycles without progress aborts the frame: ALU_EN and GATE_EN drop, then ERR (macro on) or IDLE. TX_* states wait on TX_FULL indefinitely.

## Timing
- All outputs are registered. Reset values: every strobe 0, ALU_EN=0, GATE_EN=0, REG_ADDR=0, REG_WR_DATA=0, ALU_FUN=0, TX_DATA=0; state IDLE, timeout counter 0.
- Reset asserted mid-frame: IDLE at the next edge, all enables low, captured data discarded, no partial TX.
- Latencies:
  - Final word of a write frame → REG_WR_EN: 1 cycle.
  - REG_RD_VALID → TX_VALID: 2 cycles if TX_FULL=0.
  - ALU_OUT_VALID → first TX_VALID: 2 cycles; second word 1 cycle later if TX_FULL=0.
- RX_VALID in the same cycle as the timeout expiring: the timeout wins and the word is dropped with OVR_ERR.
- REG_RD_VALID or ALU_OUT_VALID in the expiry cycle: the valid wins and the timeout is cancelled.

## Configuration
- CREM_ERR_RESP_EN defined:
  - Unknown opcodes and timeouts enter ERR.
  - ERR pushes one word 0xEE (zero-extended) to the FIFO, obeying TX_FULL; then IDLE.
- Undefined: the ERR state is not built. Unknown opcodes are ignored in IDLE and timeouts return directly to IDLE; no response word.

## Test plan
All scenarios use DATA_WIDTH=8, ADDR_WIDTH=4, FUN_WIDTH=4.
- Frame `AA,05,3C` → one REG_WR_EN pulse with REG_ADDR=5, REG_WR_DATA=0x3C, 1 cycle after the last word; no TX.
- Frame `BB,05`, REG_RD_DATA=0x3C returned 3 cycles after REG_RD_EN → TX_DATA=0x3C pushed exactly once.
- Frame `CC,12,34,00` with ALU_OUT=0x0046 → writes reg0=0x12 and reg1=0x34; ALU_EN and GATE_EN high until valid; pushes 0x46 then 0x00. Repeat with TX_FULL held high for 5 cycles: pushes are delayed and none are lost.
- `AA,05` then silence for TIMEOUT_CYCLES=16 → no REG_WR_EN. Macro on: 0xEE pushed. Macro off: return to IDLE; a following `AA,05,3C` completes normally.
- Opcode 0x77 → 0xEE pushed (macro on) or nothing (macro off). An RX word during TX_LO → OVR_ERR pulse, FSM unaffected.
- RST low during ALU_WAIT → at the next edge ALU_EN=0, GATE_EN=0, IDLE; a later ALU_OUT_VALID is ignored.

Source files
------------

// File: rtl/crem_cmd_ctrl.sv
// Command/response controller: decodes write, read and ALU frames from the RX byte stream.
// Define CREM_ERR_RESP_EN to build the ERR state (0xEE reply on bad opcode or frame timeout).
module crem_cmd_ctrl #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 4,
  parameter int FUN_WIDTH      = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [DATA_WIDTH-1:0]   RX_DATA,
  input  logic                    RX_VALID,
  output logic                    REG_WR_EN,
  output logic                    REG_RD_EN,
  output logic [ADDR_WIDTH-1:0]   REG_ADDR,
  output logic [DATA_WIDTH-1:0]   REG_WR_DATA,
  input  logic [DATA_WIDTH-1:0]   REG_RD_DATA,
  input  logic                    REG_RD_VALID,
  output logic                    ALU_EN,
  output logic [FUN_WIDTH-1:0]    ALU_FUN,
  output logic                    GATE_EN,
  input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
  input  logic                    ALU_OUT_VALID,
  output logic [DATA_WIDTH-1:0]   TX_DATA,
  output logic                    TX_VALID,
  input  logic                    TX_FULL,
  output logic                    OVR_ERR
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [DATA_WIDTH-1:0] OP_WR  = DATA_WIDTH'(8'hAA);
  localparam logic [DATA_WIDTH-1:0] OP_RD  = DATA_WIDTH'(8'hBB);
  localparam logic [DATA_WIDTH-1:0] OP_ALU = DATA_WIDTH'(8'hCC);
  localparam logic [DATA_WIDTH-1:0] OP_FUN = DATA_WIDTH'(8'hDD);
`ifdef CREM_ERR_RESP_EN
  localparam logic [DATA_WIDTH-1:0] ERR_WORD = DATA_WIDTH'(8'hEE);
`endif

  typedef enum logic [3:0] {
    IDLE,
    WR_ADDR,
    WR_DATA,
    RD_ADDR,
    RD_WAIT,
    OP_A,
    OP_B,
    FUN,
    ALU_WAIT,
    TX_RD,
    TX_LO,
    TX_HI
`ifdef CREM_ERR_RESP_EN
    , ERR
`endif
  } state_t;

  state_t                  state, state_nxt;
  logic [CNT_W-1:0]        cnt, cnt_nxt;
  logic [ADDR_WIDTH-1:0]   frame_addr, frame_addr_nxt;
  logic [DATA_WIDTH-1:0]   rd_data_q, rd_data_nxt;
  logic [2*DATA_WIDTH-1:0] alu_res_q, alu_res_nxt;
  logic [ADDR_WIDTH-1:0]   reg_addr_q, reg_addr_nxt;
  logic [DATA_WIDTH-1:0]   reg_wr_data_q, reg_wr_data_nxt;
  logic                    reg_wr_en_q, reg_wr_en_nxt;
  logic                    reg_rd_en_q, reg_rd_en_nxt;
  logic                    alu_en_q, alu_en_nxt;
  logic                    gate_en_q, gate_en_nxt;
  logic [FUN_WIDTH-1:0]    alu_fun_q, alu_fun_nxt;
  logic [DATA_WIDTH-1:0]   tx_data_q, tx_data_nxt;
  logic                    tx_valid_q, tx_valid_nxt;
  logic                    ovr_err_q, ovr_err_nxt;
  logic                    rx_state, timed_state, expired, abort;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state         <= IDLE;
      cnt           <= '0;
      frame_addr    <= '0;
      rd_data_q     <= '0;
      alu_res_q     <= '0;
      reg_addr_q    <= '0;
      reg_wr_data_q <= '0;
      reg_wr_en_q   <= 1'b0;
      reg_rd_en_q   <= 1'b0;
      alu_en_q      <= 1'b0;
      gate_en_q     <= 1'b0;
      alu_fun_q     <= '0;
      tx_data_q     <= '0;
      tx_valid_q    <= 1'b0;
      ovr_err_q     <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      frame_addr    <= frame_addr_nxt;
      rd_data_q     <= rd_data_nxt;
      alu_res_q     <= alu_res_nxt;
      reg_addr_q    <= reg_addr_nxt;
      reg_wr_data_q <= reg_wr_data_nxt;
      reg_wr_en_q   <= reg_wr_en_nxt;
      reg_rd_en_q   <= reg_rd_en_nxt;
      alu_en_q      <= alu_en_nxt;
      gate_en_q     <= gate_en_nxt;
      alu_fun_q     <= alu_fun_nxt;
      tx_data_q     <= tx_data_nxt;
      tx_valid_q    <= tx_valid_nxt;
      ovr_err_q     <= ovr_err_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    frame_addr_nxt  = frame_addr;
    rd_data_nxt     = rd_data_q;
    alu_res_nxt     = alu_res_q;
    reg_addr_nxt    = reg_addr_q;
    reg_wr_data_nxt = reg_wr_data_q;
    alu_en_nxt      = alu_en_q;
    gate_en_nxt     = gate_en_q;
    alu_fun_nxt     = alu_fun_q;
    tx_data_nxt     = tx_data_q;
    reg_wr_en_nxt   = 1'b0;
    reg_rd_en_nxt   = 1'b0;
    tx_valid_nxt    = 1'b0;
    ovr_err_nxt     = 1'b0;
    abort           = 1'b0;

    rx_state    = state inside {IDLE, WR_ADDR, WR_DATA, RD_ADDR, OP_A, OP_B, FUN};
    timed_state = state inside {WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OP_A, OP_B, FUN, ALU_WAIT};
    expired     = timed_state && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // A word landing on the expiry cycle loses to the timeout and is reported as dropped.
    if (RX_VALID && (!rx_state || expired))
      ovr_err_nxt = 1'b1;

    case (state)
      IDLE: begin
        if (RX_VALID) begin
          if (RX_DATA == OP_WR)       state_nxt = WR_ADDR;
          else if (RX_DATA == OP_RD)  state_nxt = RD_ADDR;
          else if (RX_DATA == OP_ALU) state_nxt = OP_A;
          else if (RX_DATA == OP_FUN) state_nxt = FUN;
`ifdef CREM_ERR_RESP_EN
          else                        state_nxt = ERR;
`endif
        end
      end
      WR_ADDR: begin
        if (expired) abort = 1'b1;
        else if (RX_VALID) begin
          frame_addr_nxt = RX_DATA[ADDR_WIDTH-1:0];
          state_nxt      = WR_DATA;
        end
      end
      WR_DATA: begin
        if (expired) abort = 1'b1;
        else if (RX_VALID) begin
          reg_wr_en_nxt   = 1'b1;
          reg_addr_nxt    = frame_addr;
          reg_wr_data_nxt = RX_DATA;
          state_nxt       = IDLE;
        end
      end
      RD_ADDR: begin
        if (expired) abort = 1'b1;
        else if (RX_VALID) begin
          reg_rd_en_nxt = 1'b1;
          reg_addr_nxt  = RX_DATA[ADDR_WIDTH-1:0];
          state_nxt     = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (REG_RD_VALID) begin
          rd_data_nxt = REG_RD_DATA;
          state_nxt   = TX_RD;
        end else if (expired) abort = 1'b1;
      end
      OP_A: begin
        if (expired) abort = 1'b1;
        else if (RX_VALID) begin
          reg_wr_en_nxt   = 1'b1;
          reg_addr_nxt    = ADDR_WIDTH'(0);
          reg_wr_data_nxt = RX_DATA;
          state_nxt       = OP_B;
        end
      end
      OP_B: begin
        if (expired) abort = 1'b1;
        else if (RX_VALID) begin
          reg_wr_en_nxt   = 1'b1;
          reg_addr_nxt    = ADDR_WIDTH'(1);
          reg_wr_data_nxt = RX_DATA;
          state_nxt       = FUN;
        end
      end
      FUN: begin
        if (expired) abort = 1'b1;
        else if (RX_VALID) begin
          alu_fun_nxt = RX_DATA[FUN_WIDTH-1:0];
          alu_en_nxt  = 1'b1;
          gate_en_nxt = 1'b1;
          state_nxt   = ALU_WAIT;
        end
      end
      ALU_WAIT: begin
        if (ALU_OUT_VALID) begin
          alu_res_nxt = ALU_OUT;
          alu_en_nxt  = 1'b0;
          gate_en_nxt = 1'b0;
          state_nxt   = TX_LO;
        end else if (expired) abort = 1'b1;
      end
      TX_RD: begin
        if (!TX_FULL) begin
          tx_valid_nxt = 1'b1;
          tx_data_nxt  = rd_data_q;
          state_nxt    = IDLE;
        end
      end
      TX_LO: begin
        if (!TX_FULL) begin
          tx_valid_nxt = 1'b1;
          tx_data_nxt  = alu_res_q[DATA_WIDTH-1:0];
          state_nxt    = TX_HI;
        end
      end
      TX_HI: begin
        if (!TX_FULL) begin
          tx_valid_nxt = 1'b1;
          tx_data_nxt  = alu_res_q[2*DATA_WIDTH-1:DATA_WIDTH];
          state_nxt    = IDLE;
        end
      end
`ifdef CREM_ERR_RESP_EN
      ERR: begin
        if (!TX_FULL) begin
          tx_valid_nxt = 1'b1;
          tx_data_nxt  = ERR_WORD;
          state_nxt    = IDLE;
        end
      end
`endif
      default: state_nxt = IDLE;
    endcase

    if (abort) begin
      alu_en_nxt  = 1'b0;
      gate_en_nxt = 1'b0;
`ifdef CREM_ERR_RESP_EN
      state_nxt   = ERR;
`else
      state_nxt   = IDLE;
`endif
    end

    // Every accepted word outside IDLE moves the FSM, so a state change doubles as the progress mark.
    if ((state_nxt != state) || !timed_state)
      cnt_nxt = '0;
    else
      cnt_nxt = cnt + CNT_W'(1);
  end

  assign REG_WR_EN   = reg_wr_en_q;
  assign REG_RD_EN   = reg_rd_en_q;
  assign REG_ADDR    = reg_addr_q;
  assign REG_WR_DATA = reg_wr_data_q;
  assign ALU_EN      = alu_en_q;
  assign ALU_FUN     = alu_fun_q;
  assign GATE_EN     = gate_en_q;
  assign TX_DATA     = tx_data_q;
  assign TX_VALID    = tx_valid_q;
  assign OVR_ERR     = ovr_err_q;

endmodule

// File: tb/tb_crem_cmd_ctrl.sv
// Scoreboard bench for crem_cmd_ctrl: expected TX words and register writes are queued by the
// stimulus thread and popped by a negedge monitor. Honours CREM_ERR_RESP_EN for the 0xEE replies.
module tb_crem_cmd_ctrl;
  localparam int DW = 8;
  localparam int AW = 4;
  localparam int FW = 4;
  localparam int TO = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [DW-1:0]   rx_data;
  logic            rx_valid;
  logic            reg_wr_en, reg_rd_en;
  logic [AW-1:0]   reg_addr;
  logic [DW-1:0]   reg_wr_data;
  logic [DW-1:0]   reg_rd_data;
  logic            reg_rd_valid;
  logic            alu_en, gate_en;
  logic [FW-1:0]   alu_fun;
  logic [2*DW-1:0] alu_out;
  logic            alu_out_valid;
  logic [DW-1:0]   tx_data;
  logic            tx_valid;
  logic            tx_full;
  logic            ovr_err;

  int vectors     = 0;
  int miscompares = 0;
  logic [DW-1:0]    exp_tx_q[$];
  logic [AW+DW-1:0] exp_wr_q[$];
  int   ovr_seen = 0, ovr_exp = 0, rd_en_seen = 0, rd_en_exp = 0;
  logic full_prev = 1'b0;
  bit   monitor_on = 1'b0;

  crem_cmd_ctrl #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FUN_WIDTH(FW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .CLK(clk), .RST(rst),
    .RX_DATA(rx_data), .RX_VALID(rx_valid),
    .REG_WR_EN(reg_wr_en), .REG_RD_EN(reg_rd_en), .REG_ADDR(reg_addr),
    .REG_WR_DATA(reg_wr_data), .REG_RD_DATA(reg_rd_data), .REG_RD_VALID(reg_rd_valid),
    .ALU_EN(alu_en), .ALU_FUN(alu_fun), .GATE_EN(gate_en),
    .ALU_OUT(alu_out), .ALU_OUT_VALID(alu_out_valid),
    .TX_DATA(tx_data), .TX_VALID(tx_valid), .TX_FULL(tx_full),
    .OVR_ERR(ovr_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [DW-1:0] word);
    @(posedge clk); #1;
    rx_data  = word;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic aluResult(input logic [2*DW-1:0] value);
    @(posedge clk); #1;
    alu_out       = value;
    alu_out_valid = 1'b1;
    @(posedge clk); #1;
    alu_out_valid = 1'b0;
  endtask

  // Monitor: every TX push and register write must match the head of its queue,
  // and no push may follow a cycle in which the FIFO reported full.
  always @(negedge clk) begin
    if (monitor_on) begin
      if (tx_valid) begin
        checkOutput("tx_after_full", {31'b0, full_prev}, 32'd0);
        if (exp_tx_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL tx_unexpected: got %0h, expected no push at %0t", tx_data, $time);
        end else
          checkOutput("tx_word", {24'b0, tx_data}, {24'b0, exp_tx_q.pop_front()});
      end
      if (reg_wr_en) begin
        if (exp_wr_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL wr_unexpected: got addr %0h data %0h, expected no write at %0t",
                   reg_addr, reg_wr_data, $time);
        end else
          checkOutput("reg_write", {20'b0, reg_addr, reg_wr_data}, {20'b0, exp_wr_q.pop_front()});
      end
      if (reg_rd_en) rd_en_seen++;
      if (ovr_err)   ovr_seen++;
    end
    full_prev = tx_full;
  end

  initial begin
    rst = 1'b0; rx_data = '0; rx_valid = 1'b0; reg_rd_data = '0; reg_rd_valid = 1'b0;
    alu_out = '0; alu_out_valid = 1'b0; tx_full = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_reg_wr_en", {31'b0, reg_wr_en}, 32'd0);
    checkOutput("rst_reg_rd_en", {31'b0, reg_rd_en}, 32'd0);
    checkOutput("rst_alu_en",    {31'b0, alu_en}, 32'd0);
    checkOutput("rst_gate_en",   {31'b0, gate_en}, 32'd0);
    checkOutput("rst_reg_addr",  {28'b0, reg_addr}, 32'd0);
    checkOutput("rst_wr_data",   {24'b0, reg_wr_data}, 32'd0);
    checkOutput("rst_alu_fun",   {28'b0, alu_fun}, 32'd0);
    checkOutput("rst_tx_data",   {24'b0, tx_data}, 32'd0);
    checkOutput("rst_tx_valid",  {31'b0, tx_valid}, 32'd0);
    checkOutput("rst_ovr_err",   {31'b0, ovr_err}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    monitor_on = 1'b1;

    // Write frame: strobe one cycle after the data word.
    exp_wr_q.push_back({4'h5, 8'h3C});
    applyStimulus(8'hAA); applyStimulus(8'h05); applyStimulus(8'h3C);
    @(negedge clk);
    checkOutput("wr_latency", {31'b0, reg_wr_en}, 32'd1);
    repeat (3) @(posedge clk);

    // Read frame: data returned 3 cycles after the read strobe, pushed 2 cycles later.
    applyStimulus(8'hBB); applyStimulus(8'h05);
    rd_en_exp++;
    @(negedge clk);
    checkOutput("rd_en_strobe", {31'b0, reg_rd_en}, 32'd1);
    checkOutput("rd_addr", {28'b0, reg_addr}, 32'd5);
    repeat (3) @(posedge clk);
    #1;
    reg_rd_data = 8'h3C; reg_rd_valid = 1'b1;
    exp_tx_q.push_back(8'h3C);
    @(posedge clk); #1;
    reg_rd_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("rd_tx_latency", {31'b0, tx_valid}, 32'd1);
    repeat (3) @(posedge clk);

    // ALU frame with operands, free-flowing FIFO.
    exp_wr_q.push_back({4'h0, 8'h12});
    exp_wr_q.push_back({4'h1, 8'h34});
    applyStimulus(8'hCC); applyStimulus(8'h12); applyStimulus(8'h34); applyStimulus(8'h00);
    @(negedge clk);
    checkOutput("alu_en_on", {31'b0, alu_en}, 32'd1);
    checkOutput("gate_en_on", {31'b0, gate_en}, 32'd1);
    repeat (4) @(negedge clk);
    checkOutput("alu_en_hold", {31'b0, alu_en}, 32'd1);
    exp_tx_q.push_back(8'h46);
    exp_tx_q.push_back(8'h00);
    aluResult(16'h0046);
    @(negedge clk);
    checkOutput("alu_en_drop", {31'b0, alu_en}, 32'd0);
    checkOutput("gate_en_drop", {31'b0, gate_en}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("alu_tx_lo_latency", {31'b0, tx_valid}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    checkOutput("alu_tx_hi_latency", {31'b0, tx_valid}, 32'd1);
    repeat (3) @(posedge clk);

    // Same frame with the FIFO full for 5 cycles and a stray RX word during TX_LO.
    exp_wr_q.push_back({4'h0, 8'h12});
    exp_wr_q.push_back({4'h1, 8'h34});
    applyStimulus(8'hCC); applyStimulus(8'h12); applyStimulus(8'h34); applyStimulus(8'h00);
    tx_full = 1'b1;
    exp_tx_q.push_back(8'h46);
    exp_tx_q.push_back(8'h00);
    aluResult(16'h0046);
    applyStimulus(8'hAA);
    ovr_exp++;
    @(negedge clk);
    checkOutput("ovr_in_tx_lo", {31'b0, ovr_err}, 32'd1);
    checkOutput("held_while_full", {31'b0, tx_valid}, 32'd0);
    @(posedge clk); #1;
    tx_full = 1'b0;
    repeat (6) @(posedge clk);

    // Operand-less ALU frame, both result halves distinct.
    applyStimulus(8'hDD); applyStimulus(8'h03);
    @(negedge clk);
    checkOutput("dd_alu_fun", {28'b0, alu_fun}, 32'd3);
    checkOutput("dd_gate_en", {31'b0, gate_en}, 32'd1);
    exp_tx_q.push_back(8'h5A);
    exp_tx_q.push_back(8'hA5);
    aluResult(16'hA55A);
    repeat (5) @(posedge clk);

    // Data word on the last tolerated cycle is still accepted.
    exp_wr_q.push_back({4'h5, 8'h7E});
    applyStimulus(8'hAA); applyStimulus(8'h05);
    repeat (TO - 3) @(posedge clk);
    applyStimulus(8'h7E);
    @(negedge clk);
    checkOutput("timeout_edge_accept", {31'b0, reg_wr_en}, 32'd1);
    repeat (3) @(posedge clk);

    // Data word on the expiry cycle is dropped; then a fresh frame completes.
`ifdef CREM_ERR_RESP_EN
    exp_tx_q.push_back(8'hEE);
`endif
    applyStimulus(8'hAA); applyStimulus(8'h05);
    repeat (TO - 2) @(posedge clk);
    applyStimulus(8'h3C);
    ovr_exp++;
    @(negedge clk);
    checkOutput("timeout_ovr", {31'b0, ovr_err}, 32'd1);
    checkOutput("timeout_no_write", {31'b0, reg_wr_en}, 32'd0);
    repeat (5) @(posedge clk);
    exp_wr_q.push_back({4'h5, 8'h3C});
    applyStimulus(8'hAA); applyStimulus(8'h05); applyStimulus(8'h3C);
    repeat (3) @(posedge clk);

    // ALU result never arrives: enables drop after the timeout, a late result is ignored.
`ifdef CREM_ERR_RESP_EN
    exp_tx_q.push_back(8'hEE);
`endif
    applyStimulus(8'hDD); applyStimulus(8'h01);
    repeat (TO + 4) @(posedge clk);
    @(negedge clk);
    checkOutput("alu_timeout_en", {31'b0, alu_en}, 32'd0);
    checkOutput("alu_timeout_gate", {31'b0, gate_en}, 32'd0);
    aluResult(16'h7777);
    repeat (3) @(posedge clk);

    // Unknown opcode, then a normal write frame.
`ifdef CREM_ERR_RESP_EN
    exp_tx_q.push_back(8'hEE);
`endif
    applyStimulus(8'h77);
    repeat (4) @(posedge clk);
    exp_wr_q.push_back({4'h1, 8'h55});
    applyStimulus(8'hAA); applyStimulus(8'h01); applyStimulus(8'h55);
    repeat (3) @(posedge clk);

    // Reset during ALU_WAIT discards the frame.
    applyStimulus(8'hDD); applyStimulus(8'h02);
    @(negedge clk);
    checkOutput("pre_reset_alu_en", {31'b0, alu_en}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("reset_alu_en", {31'b0, alu_en}, 32'd0);
    checkOutput("reset_gate_en", {31'b0, gate_en}, 32'd0);
    checkOutput("reset_alu_fun", {28'b0, alu_fun}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    aluResult(16'h1234);
    repeat (4) @(posedge clk);
    exp_wr_q.push_back({4'h3, 8'h99});
    applyStimulus(8'hAA); applyStimulus(8'h03); applyStimulus(8'h99);
    repeat (5) @(posedge clk);

    @(negedge clk);
    checkOutput("tx_queue_drained", exp_tx_q.size(), 32'd0);
    checkOutput("wr_queue_drained", exp_wr_q.size(), 32'd0);
    checkOutput("ovr_err_count", ovr_seen, ovr_exp);
    checkOutput("rd_en_count", rd_en_seen, rd_en_exp);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
